// File: rtl/circsat_pkg.sv
// Shared types and helpers for the exhaustive circuit-satisfiability scanner.
package circsat_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_t;

  // Size of the candidate space for an n-input circuit.
  function automatic int unsigned space(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/circsat_search_if.sv
// Scanner <-> circuit/host signal bundle; the circuit under search hangs off cand/y.
interface circsat_search_if #(
  parameter int unsigned N = 3
);
  logic         start;
  logic [N-1:0] cand;
  logic         y;
  logic         busy;
  logic         done;
  logic         found;
  logic [N-1:0] first_sol;
  logic [N:0]   sol_count;

  modport master (
    output start, y,
    input  cand, busy, done, found, first_sol, sol_count
  );

  modport slave (
    input  start, y,
    output cand, busy, done, found, first_sol, sol_count
  );
endinterface

// File: rtl/circsat_search.sv
// Enumerates all 2^N input assignments, one per clock, counting satisfying ones and
// capturing the lowest. All outputs are registered.
module circsat_search
  import circsat_pkg::*;
#(
  parameter int unsigned N          = 3,
  parameter bit          STOP_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  circsat_search_if.slave  bus
);

  localparam int unsigned  Space    = space(N);
  localparam logic [N-1:0] LastCand = N'(Space - 1);

  state_t       state_q, state_d;
  logic [N-1:0] cand_q, cand_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         found_q, found_d;
  logic [N-1:0] first_q, first_d;
  logic [N:0]   count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cand_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      first_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      found_q <= found_d;
      first_q <= first_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    busy_d  = busy_q;
    done_d  = done_q;
    found_d = found_q;
    first_d = first_q;
    count_d = count_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StScan;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          cand_d  = '0;
          found_d = 1'b0;
          first_d = '0;
          count_d = '0;
        end
      end
      StScan: begin
        if (bus.y) begin
          count_d = count_q + (N+1)'(1);
          if (!found_q) begin
            first_d = cand_q;
            found_d = 1'b1;
          end
        end
        // Terminal check precedes the increment, so cand never wraps.
        if (cand_q == LastCand || (STOP_FIRST && bus.y)) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cand_d = cand_q + N'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.cand      = cand_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.found     = found_q;
  assign bus.first_sol = first_q;
  assign bus.sol_count = count_q;

endmodule

// File: tb/tb_circsat_search.sv
// Scoreboard bench: two scanners (full scan and stop-at-first) driven by a selectable circuit.
module tb_circsat_search;

  typedef struct {
    logic       found;
    logic [2:0] first;
    logic [3:0] count;
    int         len;
  } exp_t;

  logic clk;
  logic rst_n;
  int   mode;  // 0: y = a&b&~c, 1: y = 0, 2: y = 1
  int   tests;
  int   fails;

  exp_t q0[$];
  exp_t q1[$];

  circsat_search_if #(.N(3)) bus0 ();
  circsat_search_if #(.N(3)) bus1 ();

  circsat_search #(.N(3), .STOP_FIRST(1'b0)) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  circsat_search #(.N(3), .STOP_FIRST(1'b1)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  function automatic logic y_fn(input int m, input logic [2:0] c);
    if (m == 0) return c == 3'b110;
    if (m == 1) return 1'b0;
    return 1'b1;
  endfunction

  assign bus0.y = y_fn(mode, bus0.cand);
  assign bus1.y = y_fn(mode, bus1.cand);

  logic [1:0] busy_w, done_w, found_w;
  logic [2:0] cand_w[2];
  logic [2:0] first_w[2];
  logic [3:0] cnt_w[2];

  assign busy_w   = {bus1.busy, bus0.busy};
  assign done_w   = {bus1.done, bus0.done};
  assign found_w  = {bus1.found, bus0.found};
  assign cand_w[0]  = bus0.cand;
  assign cand_w[1]  = bus1.cand;
  assign first_w[0] = bus0.first_sol;
  assign first_w[1] = bus1.first_sol;
  assign cnt_w[0]   = bus0.sol_count;
  assign cnt_w[1]   = bus1.sol_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs(input int d);
    return {20'd0, busy_w[d], done_w[d], found_w[d], first_w[d], cnt_w[d], cand_w[d]};
  endfunction

  // Monitor: cand must step 0,1,2,... while busy; each done rise pops one expectation.
  int   busy_cnt[2];
  logic prev_done[2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        busy_cnt[d]  = 0;
        prev_done[d] = 1'b0;
      end else begin
        if (busy_w[d]) begin
          check($sformatf("cand_seq%0d", d), cand_w[d], busy_cnt[d]);
          busy_cnt[d]++;
        end
        if (done_w[d] && !prev_done[d]) begin
          exp_t e;
          int   sz;
          sz = (d == 0) ? q0.size() : q1.size();
          if (sz == 0) begin
            check($sformatf("unexpected_done%0d", d), 1, 0);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("found%0d", d), found_w[d], e.found);
            check($sformatf("first_sol%0d", d), first_w[d], e.first);
            check($sformatf("sol_count%0d", d), cnt_w[d], e.count);
            check($sformatf("scan_len%0d", d), busy_cnt[d], e.len);
          end
          busy_cnt[d] = 0;
        end
        prev_done[d] = done_w[d];
      end
    end
  end

  task automatic pulse_start(input logic [1:0] mask);
    @(negedge clk);
    bus0.start = mask[0];
    bus1.start = mask[1];
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    @(negedge clk);
    while (!done_w[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done_w[d]) check($sformatf("done_timeout%0d", d), 0, 1);
  endtask

  task automatic wait_cand(input int d, input logic [2:0] v);
    int n;
    n = 0;
    while (cand_w[d] != v && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (cand_w[d] != v) check("cand_wait_timeout", cand_w[d], v);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    mode       = 0;
    rst_n      = 1'b0;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_idle0", outs(0), 0);
      check("reset_idle1", outs(1), 0);
    end

    // Single satisfying assignment 110.
    mode = 0;
    q0.push_back('{found: 1'b1, first: 3'd6, count: 4'd1, len: 8});
    q1.push_back('{found: 1'b1, first: 3'd6, count: 4'd1, len: 7});
    pulse_start(2'b11);
    wait_done(0);
    check("hold_cand0", cand_w[0], 7);
    check("hold_cand1", cand_w[1], 6);

    // Unsatisfiable.
    mode = 1;
    q0.push_back('{found: 1'b0, first: 3'd0, count: 4'd0, len: 8});
    q1.push_back('{found: 1'b0, first: 3'd0, count: 4'd0, len: 8});
    pulse_start(2'b11);
    wait_done(0);

    // Tautology: count reaches 8 without overflow.
    mode = 2;
    q0.push_back('{found: 1'b1, first: 3'd0, count: 4'd8, len: 8});
    q1.push_back('{found: 1'b1, first: 3'd0, count: 4'd1, len: 1});
    pulse_start(2'b11);
    wait_done(0);
    @(negedge clk);
    check("done_holds", done_w[0], 1);

    // Start from DONE clears results and rescans.
    q0.push_back('{found: 1'b1, first: 3'd0, count: 4'd8, len: 8});
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    check("restart_done", done_w[0], 0);
    check("restart_busy", busy_w[0], 1);
    check("restart_found", found_w[0], 0);
    check("restart_count", cnt_w[0], 0);
    wait_done(0);

    // Start during SCAN is ignored.
    mode = 1;
    q0.push_back('{found: 1'b0, first: 3'd0, count: 4'd0, len: 8});
    pulse_start(2'b01);
    wait_cand(0, 3'd3);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    wait_done(0);

    // Start held high: back-to-back scans with a one-cycle DONE.
    mode = 0;
    q0.push_back('{found: 1'b1, first: 3'd6, count: 4'd1, len: 8});
    q0.push_back('{found: 1'b1, first: 3'd6, count: 4'd1, len: 8});
    @(negedge clk);
    bus0.start = 1'b1;
    wait_done(0);
    @(negedge clk);
    check("rescan_busy", busy_w[0], 1);
    check("rescan_done", done_w[0], 0);
    bus0.start = 1'b0;
    wait_done(0);

    // Asynchronous reset mid-scan.
    pulse_start(2'b01);
    wait_cand(0, 3'd4);
    rst_n = 1'b0;
    #1;
    check("midscan_reset0", outs(0), 0);
    check("midscan_reset1", outs(1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset0", outs(0), 0);

    repeat (2) @(negedge clk);
    check("pending_q0", q0.size(), 0);
    check("pending_q1", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/circsat_search.md
Name: circsat_search

Overview:
- Sequential driver/collector for a combinational circuit-satisfiability block such as circsat.
- On a start request, enumerates every input assignment, one per clock, and drives it onto the circuit's inputs.
- Samples the circuit's single output y each cycle, counts satisfying assignments and captures the first one found.
- Gives a classical, exhaustive reference answer to check annealer results against.

Parameters:
- N, 3, number of circuit inputs; candidate space is 2^N (N >= 1).
- STOP_FIRST, 0, 1 = end the scan at the first satisfying assignment; 0 = scan the full space.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a scan; sampled in IDLE and DONE only.
- cand  output  N  candidate assignment to the circuit; cand[N-1] = first input (a), cand[0] = last input (c).
- y  input  1  circuit output for the current cand, combinational same-cycle.
- busy  output  1  high while scanning.
- done  output  1  high from scan completion until the next start or reset.
- found  output  1  at least one satisfying assignment seen in the current/last scan.
- first_sol  output  N  lowest satisfying cand; 0 when found = 0.
- sol_count  output  N+1  number of satisfying assignments (0 .. 2^N).

Behaviour:
- Reset (async assert, sync release): state = IDLE; cand = 0, busy = 0, done = 0, found = 0, first_sol = 0, sol_count = 0.
- FSM states IDLE, SCAN, DONE. The state register and every output are registered.
- IDLE, start = 1:
  - next state SCAN, busy = 1, cand = 0;
  - clear found, first_sol and sol_count in the same edge.
- SCAN, each rising edge evaluates y for the cand currently driven:
  - if y = 1: sol_count += 1; if found = 0, then first_sol <= cand and found <= 1.
  - terminate if cand = 2^N - 1, or if STOP_FIRST = 1 and y = 1: next state DONE, busy = 0, done = 1, cand holds its value.
  - otherwise cand <= cand + 1, computed in N bits; wrap never occurs because the terminal check comes first.
- Scan latency: full scan takes exactly 2^N cycles in SCAN; done rises on the edge after the last candidate is evaluated.
- DONE: outputs hold. start = 1 behaves as in IDLE and done drops on that edge.
- start in SCAN is ignored; the scan is neither restarted nor extended.
- Circuit delay: y must settle within one clock period of a cand change; there is no extra pipeline stage.
- sol_count is N+1 bits, so the all-satisfiable case (2^N) does not overflow.
- Reset mid-scan: immediate return to the reset values; no partial result is retained.
- start held high continuously: rescans back-to-back. Each DONE lasts one cycle, then SCAN restarts.

Decomposition:
- Shared package circsat_pkg holds:
  - the FSM state enum (IDLE, SCAN, DONE);
  - the localparam SPACE = 2^N helper function.
- No sub-module. The circuit under search is instantiated by the parent/testbench, not inside this block, so any f can be attached.

Test Plan:
- Reset with start = 0 → all outputs 0, state IDLE, for 10 cycles.
- circsat attached (y = 1 only for a=1, b=1, c=0), N = 3, STOP_FIRST = 0, start pulse:
  - busy high for 8 cycles, cand sequencing 0..7;
  - done = 1, found = 1, first_sol = 3'b110, sol_count = 1.
- Same circuit, STOP_FIRST = 1 → done after 7 SCAN cycles (cand reaches 6), first_sol = 6, sol_count = 1.
- Stub y = 0 (unsatisfiable) → after 8 cycles done = 1, found = 0, first_sol = 0, sol_count = 0.
- Stub y = 1 (tautology) → first_sol = 0, sol_count = 8 (4'b1000, no overflow).
- Edge-case sequencing:
  - rst_n pulsed low at cand = 4 mid-scan → outputs 0 immediately.
  - start pulse at SCAN cycle 3 → ignored.
  - start in DONE → counters clear and a new scan begins.
